line_track_ctrl: RTL and testbench
==================================

LINE_TRACK_CTRL -- requirements
Module: line_track_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required before a track sample is accepted.
REQ-002 The block SHALL have parameter STOP_CM, default 20: obstacle-set threshold in cm.
REQ-003 The block SHALL have parameter RESUME_CM, default 25: obstacle-clear threshold in cm, with RESUME_CM > STOP_CM.
REQ-004 The block SHALL have parameter SEARCH_CYCLES, default 50_000_000: lost-line search timeout in clk cycles.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 left_track, mid_track, right_track  input  1 each  raw, asynchronous track sensors; 1 = line under sensor.
REQ-008 distance  input  20  ultrasonic range in cm from sonic_top, clk-synchronous.
REQ-009 mode  output  2  motor command to motor: 00 STOP, 01 FWD, 10 LEFT, 11 RIGHT.
REQ-010 obstacle  output  1  registered hysteresis obstacle flag (debug).

Function
REQ-011 Each track input SHALL pass a 2-FF synchronizer.
REQ-012 The debounced vector trk[2:0] = {l,m,r} SHALL update only after the synchronized vector has been identical for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-013 distance SHALL be registered once before comparison.
REQ-014 The obstacle flag SHALL set when registered distance < STOP_CM, clear when it is > RESUME_CM, and hold for STOP_CM..RESUME_CM inclusive.
REQ-015 The FSM SHALL have states OBST, FWD, LEFT, RIGHT, SEARCH, LOST.
REQ-016 When obstacle = 1, the next state SHALL be OBST from any state; this has highest priority.
REQ-017 When obstacle = 0, the next state SHALL be decided by trk: 010/111/101 -> FWD; 110/100 -> LEFT; 011/001 -> RIGHT; 000 -> SEARCH.
REQ-018 The one exception to REQ-017 SHALL be LOST with trk = 000, which stays LOST.
REQ-019 A last_dir register SHALL be written LEFT on entry to LEFT and RIGHT on entry to RIGHT; its reset value is LEFT.
REQ-020 SEARCH SHALL drive mode = last_dir.
REQ-021 The search counter SHALL clear on SEARCH entry and increment each cycle in SEARCH.
REQ-022 On reaching SEARCH_CYCLES-1 in SEARCH with trk = 000, the next state SHALL be LOST.
REQ-023 LOST and OBST SHALL drive mode = STOP.
REQ-024 Leaving OBST SHALL apply REQ-017 to the current trk; the search counter restarts if the result is SEARCH.
REQ-025 mode SHALL be registered and update on the same edge as the state register: state X -> mode(X), no extra latency.
REQ-026 Latency from a raw track edge to mode change SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-027 Latency from a distance change to obstacle SHALL be 2 cycles; mode SHALL follow 1 cycle later.
REQ-028 The debounce and search counters SHALL saturate and never wrap.

Reset
REQ-029 While rst = 0, the block SHALL hold: state = OBST, mode = 00, obstacle = 1, trk = 000, last_dir = LEFT, all counters and synchronizers 0.
REQ-030 Reset SHALL take effect asynchronously mid-operation.
REQ-031 After release, the first non-STOP mode SHALL occur only after the obstacle flag clears.

Structure
REQ-032 Mode encodings, state encodings, and default thresholds SHALL live in shared package lab6_pkg, also used by motor.
REQ-033 Synchronizer plus debounce SHALL be sub-module track_debounce (width 3, parameter DEBOUNCE_CYCLES).
REQ-034 The FSM, hysteresis logic and search timer SHALL stay in line_track_ctrl.

Verification (DEBOUNCE_CYCLES=4, SEARCH_CYCLES=16, STOP_CM=20, RESUME_CM=25)
REQ-035 Reset with distance=100 and trk=010: obstacle clears 2 cycles after release, then mode=01; mode=00 throughout reset.
REQ-036 Distance sweep 30->22->19->22->24->26: obstacle is 0,0,1,1,1,0 and mode follows with STOP during 1.
REQ-037 trk 010 -> 110 for 3 cycles -> 010 gives no mode change; held for 7+ cycles gives mode=10.
REQ-038 Track set to 001 then 000 for 30 cycles: mode=11 for 16 cycles, then 00 (LOST); then 010 gives mode=01 after debounce.
REQ-039 Obstacle asserted while in SEARCH: mode=00 immediately next cycle; on clear with trk=000, a full 16-cycle SEARCH restarts.
REQ-040 rst pulsed low mid-LEFT: mode=00 asynchronously and last_dir returns to LEFT.

Source files
------------

// File: rtl/lab6_pkg.sv
// Shared encodings and defaults for the line-tracking car: motor commands, controller
// states and the decode from debounced track bits to the steering state.
package lab6_pkg;

    typedef enum logic [1:0] {
        ModeStop  = 2'b00,
        ModeFwd   = 2'b01,
        ModeLeft  = 2'b10,
        ModeRight = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        StObst   = 3'd0,
        StFwd    = 3'd1,
        StLeft   = 3'd2,
        StRight  = 3'd3,
        StSearch = 3'd4,
        StLost   = 3'd5
    } state_e;

    localparam int unsigned DistW             = 20;
    localparam int unsigned DefDebounceCycles = 1000;
    localparam int unsigned DefStopCm         = 20;
    localparam int unsigned DefResumeCm       = 25;
    localparam int unsigned DefSearchCycles   = 50_000_000;

    // trk = {left, mid, right}; 1 = line under sensor
    function automatic state_e trk_state(input logic [2:0] trk);
        state_e st;
        case (trk)
            3'b010, 3'b111, 3'b101: st = StFwd;
            3'b110, 3'b100:         st = StLeft;
            3'b011, 3'b001:         st = StRight;
            default:                st = StSearch;
        endcase
        return st;
    endfunction

    function automatic mode_e state_mode(input state_e st, input mode_e last_dir);
        mode_e m;
        case (st)
            StFwd:    m = ModeFwd;
            StLeft:   m = ModeLeft;
            StRight:  m = ModeRight;
            StSearch: m = last_dir;
            default:  m = ModeStop;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/line_track_ctrl_if.sv
// Sensor/motor bundle between the line-tracking controller and its environment.
interface line_track_ctrl_if;
    import lab6_pkg::*;

    logic             left_track;
    logic             mid_track;
    logic             right_track;
    logic [DistW-1:0] distance;
    mode_e            mode;
    logic             obstacle;

    modport master (
        output left_track, mid_track, right_track, distance,
        input  mode, obstacle
    );

    modport slave (
        input  left_track, mid_track, right_track, distance,
        output mode, obstacle
    );

endinterface

// File: rtl/track_debounce.sv
// Two-flop synchronizer followed by a stability debounce: the output only takes a new
// value once the synchronized input has held it for DEBOUNCE_CYCLES consecutive samples.
module track_debounce #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = lab6_pkg::DefDebounceCycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);

    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] meta_q, sync_q, hold_q;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // cnt_d is the number of consecutive samples (including this one) equal to sync_q
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_q != hold_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (cnt_d == CntMax) begin
            deb_d = sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            hold_q <= sync_q;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/line_track_ctrl.sv
// Line-tracking controller: debounced track steering, obstacle hysteresis on the sonar
// range, and a timed search for a lost line before giving up and stopping.
module line_track_ctrl
    import lab6_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned STOP_CM         = DefStopCm,
    parameter int unsigned RESUME_CM       = DefResumeCm,
    parameter int unsigned SEARCH_CYCLES   = DefSearchCycles
) (
    input  logic           clk,
    input  logic           rst,
    line_track_ctrl_if.slave bus
);

    localparam int unsigned      ScntW     = (SEARCH_CYCLES > 2) ? $clog2(SEARCH_CYCLES) : 1;
    localparam logic [ScntW-1:0] ScntLast  = ScntW'(SEARCH_CYCLES - 1);
    localparam logic [DistW-1:0] StopCmW   = DistW'(STOP_CM);
    localparam logic [DistW-1:0] ResumeCmW = DistW'(RESUME_CM);

    logic [2:0]       trk;
    logic [DistW-1:0] dist_q;
    logic             obstacle_q, obstacle_d;
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    mode_e            last_dir_q, last_dir_d;
    logic [ScntW-1:0] scnt_q, scnt_d;

    track_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_track_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw_i({bus.left_track, bus.mid_track, bus.right_track}),
        .deb_o(trk)
    );

    // Hold band STOP_CM..RESUME_CM keeps the flag from chattering near the threshold
    always_comb begin
        obstacle_d = obstacle_q;
        if (dist_q < StopCmW) begin
            obstacle_d = 1'b1;
        end else if (dist_q > ResumeCmW) begin
            obstacle_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = trk_state(trk);
        last_dir_d = last_dir_q;
        scnt_d     = scnt_q;

        if (obstacle_q) begin
            state_d = StObst;
        end else if (trk == 3'b000 &&
                     (state_q == StLost || (state_q == StSearch && scnt_q == ScntLast))) begin
            state_d = StLost;
        end

        if (state_d == StLeft) begin
            last_dir_d = ModeLeft;
        end else if (state_d == StRight) begin
            last_dir_d = ModeRight;
        end

        // Every fresh entry into SEARCH (including from OBST) gets the full timeout
        if (state_d == StSearch) begin
            if (state_q != StSearch) begin
                scnt_d = '0;
            end else if (scnt_q != ScntLast) begin
                scnt_d = scnt_q + ScntW'(1);
            end
        end

        mode_d = state_mode(state_d, last_dir_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dist_q     <= '0;
            obstacle_q <= 1'b1;
            state_q    <= StObst;
            mode_q     <= ModeStop;
            last_dir_q <= ModeLeft;
            scnt_q     <= '0;
        end else begin
            dist_q     <= bus.distance;
            obstacle_q <= obstacle_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            last_dir_q <= last_dir_d;
            scnt_q     <= scnt_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.obstacle = obstacle_q;

endmodule

// File: tb/tb_line_track_ctrl.sv
// Scoreboard bench: expected mode/obstacle values are queued with the cycle at which they
// must appear, and a monitor compares them just after each rising edge.
module tb_line_track_ctrl;
    import lab6_pkg::*;

    typedef struct {
        int         at;
        string      tag;
        logic [1:0] mode;
        logic       obst;
    } exp_t;

    logic clk;
    logic rst;
    line_track_ctrl_if bus ();

    line_track_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STOP_CM        (20),
        .RESUME_CM      (25),
        .SEARCH_CYCLES  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   b;
    int   dist_tab [6];
    logic ob_tab   [6];
    logic prev_ob;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int at, input string tag, input logic [1:0] m, input logic o);
        exp_t e;
        int   i;
        e.at   = at;
        e.tag  = tag;
        e.mode = m;
        e.obst = o;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    task automatic set_trk(input logic [2:0] v);
        {bus.left_track, bus.mid_track, bus.right_track} = v;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                check({e.tag, "/mode"}, 32'(bus.mode), 32'(e.mode));
                check({e.tag, "/obst"}, 32'(bus.obstacle), 32'(e.obst));
            end
        end
    end

    initial begin
        dist_tab = '{30, 22, 19, 22, 24, 26};
        ob_tab   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst          = 1'b1;
        bus.distance = 20'd100;
        set_trk(3'b010);
        #2 rst = 1'b0;

        // Reset hold, then release: obstacle clears on the 2nd edge
        @(negedge clk);
        check("rst_mode", 32'(bus.mode), 32'(ModeStop));
        check("rst_obst", 32'(bus.obstacle), 32'd1);
        b = cyc;
        push(b + 1, "rst_hold1", 2'b00, 1'b1);
        push(b + 2, "rst_hold2", 2'b00, 1'b1);
        wait_neg(3);
        rst = 1'b1;
        b   = cyc;
        push(b + 1, "rel_e1", 2'b00, 1'b1);
        push(b + 2, "rel_clear", 2'b00, 1'b0);
        push(b + 3, "rel_search", 2'b10, 1'b0);
        push(b + 7, "rel_fwd", 2'b01, 1'b0);
        wait_neg(8);

        // Distance sweep through the hysteresis band
        prev_ob = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.distance = 20'(dist_tab[i]);
            b = cyc;
            push(b + 1, $sformatf("sweep%0d_e1", i), prev_ob ? 2'b00 : 2'b01, prev_ob);
            push(b + 2, $sformatf("sweep%0d_e2", i), prev_ob ? 2'b00 : 2'b01, ob_tab[i]);
            push(b + 3, $sformatf("sweep%0d_e3", i), ob_tab[i] ? 2'b00 : 2'b01, ob_tab[i]);
            wait_neg(3);
            prev_ob = ob_tab[i];
        end

        // Short glitch is rejected by the debounce
        set_trk(3'b110);
        b = cyc;
        for (int k = 1; k <= 14; k++) push(b + k, $sformatf("glitch%0d", k), 2'b01, 1'b0);
        wait_neg(3);
        set_trk(3'b010);
        wait_neg(11);

        set_trk(3'b110);
        b = cyc;
        push(b + 6, "left_pre", 2'b01, 1'b0);
        push(b + 7, "left", 2'b10, 1'b0);
        wait_neg(8);

        set_trk(3'b001);
        b = cyc;
        push(b + 6, "right_pre", 2'b10, 1'b0);
        push(b + 7, "right", 2'b11, 1'b0);
        wait_neg(8);

        // Line lost: 16 cycles of SEARCH (last_dir = RIGHT), then LOST
        set_trk(3'b000);
        b = cyc;
        push(b + 6, "srch_pre", 2'b11, 1'b0);
        push(b + 7, "srch_first", 2'b11, 1'b0);
        push(b + 22, "srch_last", 2'b11, 1'b0);
        push(b + 23, "lost", 2'b00, 1'b0);
        push(b + 30, "lost_hold", 2'b00, 1'b0);
        wait_neg(30);

        set_trk(3'b010);
        b = cyc;
        push(b + 6, "lost_pre", 2'b00, 1'b0);
        push(b + 7, "lost_fwd", 2'b01, 1'b0);
        wait_neg(8);

        // Obstacle mid-SEARCH, then a full search restart on clear
        set_trk(3'b000);
        b = cyc;
        push(b + 7, "srch2_in", 2'b11, 1'b0);
        wait_neg(10);
        bus.distance = 20'd10;
        b = cyc;
        push(b + 1, "obs_e1", 2'b11, 1'b0);
        push(b + 2, "obs_e2", 2'b11, 1'b1);
        push(b + 3, "obs_stop", 2'b00, 1'b1);
        wait_neg(6);
        bus.distance = 20'd100;
        b = cyc;
        push(b + 1, "clr_e1", 2'b00, 1'b1);
        push(b + 2, "clr_e2", 2'b00, 1'b0);
        push(b + 3, "restart_first", 2'b11, 1'b0);
        push(b + 18, "restart_last", 2'b11, 1'b0);
        push(b + 19, "restart_lost", 2'b00, 1'b0);
        wait_neg(20);

        // Asynchronous reset mid-LEFT
        set_trk(3'b110);
        b = cyc;
        push(b + 6, "left2_pre", 2'b00, 1'b0);
        push(b + 7, "left2", 2'b10, 1'b0);
        wait_neg(9);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mode", 32'(bus.mode), 32'(ModeStop));
        check("async_rst_obst", 32'(bus.obstacle), 32'd1);
        @(negedge clk);
        b = cyc;
        push(b + 1, "rst2_hold1", 2'b00, 1'b1);
        push(b + 2, "rst2_hold2", 2'b00, 1'b1);
        wait_neg(2);
        rst = 1'b1;
        b   = cyc;
        push(b + 1, "rel2_e1", 2'b00, 1'b1);
        push(b + 2, "rel2_clear", 2'b00, 1'b0);
        push(b + 3, "rel2_search", 2'b10, 1'b0);
        push(b + 7, "rel2_left", 2'b10, 1'b0);
        wait_neg(8);

        // Reset while RIGHT: last_dir must come back as LEFT
        set_trk(3'b001);
        b = cyc;
        push(b + 7, "right2", 2'b11, 1'b0);
        wait_neg(8);
        set_trk(3'b000);
        #2 rst = 1'b0;
        #1;
        check("async_rst2_mode", 32'(bus.mode), 32'(ModeStop));
        @(negedge clk);
        rst = 1'b1;
        b   = cyc;
        push(b + 1, "rel3_e1", 2'b00, 1'b1);
        push(b + 2, "rel3_clear", 2'b00, 1'b0);
        push(b + 3, "lastdir_rst", 2'b10, 1'b0);
        wait_neg(5);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
